// File: rtl/trigger_capture_pkg.sv
// Shared types for the trigger capture window: FSM states, default ring depth
// and the PRE/POST window clamp applied when a capture is armed.
package trigger_capture_pkg;

   localparam int ADDR_WIDTH_DEFAULT = 10;
   localparam int DEPTH = 1 << ADDR_WIDTH_DEFAULT;

   typedef enum logic [2:0] {IDLE, FILL, ARMED, POST, READOUT} state_t;

   typedef struct packed {
      logic [31:0] pre;
      logic [31:0] post;
   } window_t;

   // The whole window must fit in the ring, and at least the trigger sample is kept.
   function automatic window_t clamp_window(input logic [31:0] pre_req,
                                            input logic [31:0] post_req,
                                            input logic [31:0] depth);
      window_t w;
      w.pre  = (pre_req > depth - 32'd1) ? depth - 32'd1 : pre_req;
      w.post = (post_req > depth - w.pre) ? depth - w.pre : post_req;
      if (w.post == 32'd0) w.post = 32'd1;
      return w;
   endfunction

endpackage

// File: rtl/capture_ring_ram.sv
// Simple dual-port sample ring: one write port, one registered read port.
module capture_ring_ram #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  re,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [0:(1 << ADDR_WIDTH)-1];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/trigger_capture_window.sv
// Ring-buffered pre/post trigger capture, streamed oldest-first as one AXIS packet.
module trigger_capture_window
   import trigger_capture_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 10,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_data_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  trigger,
   input  logic                  arm,
   input  logic                  abort,
   input  logic [CNT_WIDTH-1:0]  pre_samples,
   input  logic [CNT_WIDTH-1:0]  post_samples,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast,
   output logic                  busy,
   output logic                  capture_done,
   output logic                  trig_seen
);

   localparam int RING_DEPTH = 1 << ADDR_WIDTH;

   state_t                state;
   logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
   logic [CNT_WIDTH-1:0]  pre_q, post_q, fill_cnt, post_cnt, issue_cnt;
   logic [CNT_WIDTH-1:0]  total_beats, post_next;
   logic                  trigger_q, trig_edge, we, re, pop;
   logic [DATA_WIDTH-1:0] rdata, skid_data;
   logic                  rd_pend, rd_pend_last, skid_valid, skid_last;
   logic [1:0]            occ;
   window_t               win;

   assign trig_edge   = trigger & ~trigger_q;
   assign we          = in_data_valid && (state == FILL || state == ARMED || state == POST);
   assign win         = clamp_window(32'(pre_samples), 32'(post_samples), 32'(RING_DEPTH));
   assign total_beats = pre_q + post_q;
   assign post_next   = (post_cnt == '1) ? post_cnt : post_cnt + 1'b1;
   assign busy        = (state != IDLE);
   assign pop         = m_axis_tvalid & m_axis_tready;

   // Output register + skid hold two beats; only issue a read if its data will have a home.
   assign occ = 2'(m_axis_tvalid) + 2'(skid_valid) + 2'(rd_pend);
   assign re  = (state == READOUT) && !abort && (issue_cnt < total_beats) &&
                (occ <= 2'(pop) + 2'd1);

   capture_ring_ram #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH)
   ) u_ram (
      .clk  (clk),
      .we   (we),
      .waddr(wr_ptr),
      .wdata(in_data),
      .re   (re),
      .raddr(rd_ptr),
      .rdata(rdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         pre_q         <= '0;
         post_q        <= '0;
         fill_cnt      <= '0;
         post_cnt      <= '0;
         issue_cnt     <= '0;
         trigger_q     <= 1'b0;
         rd_pend       <= 1'b0;
         rd_pend_last  <= 1'b0;
         skid_valid    <= 1'b0;
         skid_last     <= 1'b0;
         skid_data     <= '0;
         m_axis_tdata  <= '0;
         m_axis_tvalid <= 1'b0;
         m_axis_tlast  <= 1'b0;
         capture_done  <= 1'b0;
         trig_seen     <= 1'b0;
      end else begin
         trigger_q    <= trigger;
         capture_done <= 1'b0;
         if (we) wr_ptr <= wr_ptr + 1'b1;

         if (abort) begin
            state         <= IDLE;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            skid_valid    <= 1'b0;
            rd_pend       <= 1'b0;
         end else begin
            case (state)
               IDLE: if (arm) begin
                  pre_q     <= CNT_WIDTH'(win.pre);
                  post_q    <= CNT_WIDTH'(win.post);
                  fill_cnt  <= '0;
                  trig_seen <= 1'b0;
                  state     <= FILL;
               end
               FILL: begin
                  if (we && fill_cnt != '1) fill_cnt <= fill_cnt + 1'b1;
                  if (fill_cnt >= pre_q) state <= ARMED;
               end
               ARMED: if (trig_edge) begin
                  // The trigger sample sits at wr_ptr, so the window starts PRE behind it.
                  rd_ptr    <= wr_ptr - pre_q[ADDR_WIDTH-1:0];
                  issue_cnt <= '0;
                  trig_seen <= 1'b1;
                  post_cnt  <= CNT_WIDTH'(in_data_valid);
                  state     <= (in_data_valid && post_q == CNT_WIDTH'(1)) ? READOUT : POST;
               end
               POST: if (in_data_valid) begin
                  post_cnt <= post_next;
                  if (post_next >= post_q) state <= READOUT;
               end
               READOUT: begin
                  if (re) begin
                     rd_ptr    <= rd_ptr + 1'b1;
                     issue_cnt <= issue_cnt + 1'b1;
                  end
                  rd_pend      <= re;
                  rd_pend_last <= re && (issue_cnt == total_beats - 1'b1);

                  if (pop || !m_axis_tvalid) begin
                     if (skid_valid) begin
                        m_axis_tdata  <= skid_data;
                        m_axis_tlast  <= skid_last;
                        m_axis_tvalid <= 1'b1;
                        skid_valid    <= rd_pend;
                        skid_data     <= rdata;
                        skid_last     <= rd_pend_last;
                     end else begin
                        m_axis_tdata  <= rdata;
                        m_axis_tlast  <= rd_pend_last;
                        m_axis_tvalid <= rd_pend;
                     end
                  end else if (rd_pend) begin
                     skid_valid <= 1'b1;
                     skid_data  <= rdata;
                     skid_last  <= rd_pend_last;
                  end

                  if (pop && m_axis_tlast) begin
                     capture_done  <= 1'b1;
                     m_axis_tvalid <= 1'b0;
                     m_axis_tlast  <= 1'b0;
                     skid_valid    <= 1'b0;
                     rd_pend       <= 1'b0;
                     state         <= IDLE;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_trigger_capture_window.sv
// Directed bench for trigger_capture_window with a queue-based window model.
module tb_trigger_capture_window;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_data_valid, trigger, arm, abort, m_axis_tready;
   logic [15:0] in_data, pre_samples, post_samples;
   logic [15:0] m_axis_tdata;
   logic        m_axis_tvalid, m_axis_tlast, busy, capture_done, trig_seen;

   trigger_capture_window #(.DATA_WIDTH(16), .ADDR_WIDTH(10), .CNT_WIDTH(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_data_valid(in_data_valid), .in_data(in_data),
      .trigger(trigger), .arm(arm), .abort(abort), .pre_samples(pre_samples),
      .post_samples(post_samples), .m_axis_tdata(m_axis_tdata),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
      .m_axis_tlast(m_axis_tlast), .busy(busy), .capture_done(capture_done),
      .trig_seen(trig_seen)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, expv, $time);
      end
   endtask

   // Model: phase 0 idle, 1 filling, 2 armed, 3 post, 4 streaming.
   logic [15:0] hist[$];
   logic [15:0] exp_q[$];
   logic [15:0] rx[$];
   int  ph, pre_m, post_m, fill_m, trig_idx, beat, rk;
   bit  ts_m, done_m, stalled, trig_prev, edge_m, hs;

   task automatic finish_post();
      if (hist.size() - trig_idx == post_m) begin
         exp_q.delete();
         for (int i = trig_idx - pre_m; i < trig_idx + post_m; i++) exp_q.push_back(hist[i]);
         beat = 0;
         rk   = 0;
         ph   = 4;
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ph = 0; ts_m = 0; done_m = 0; trig_prev = 0; stalled = 0; beat = 0; rk = 0;
         exp_q.delete();
      end else begin
         edge_m    = trigger && !trig_prev;
         trig_prev = trigger;
         hs        = m_axis_tvalid && m_axis_tready;
         stalled   = m_axis_tvalid && !m_axis_tready;
         done_m    = 0;
         if (ph == 4) rk++;
         if (abort) begin
            ph = 0;
            exp_q.delete();
         end else begin
            case (ph)
               0: if (arm) begin
                  pre_m  = (pre_samples > 16'd1023) ? 1023 : int'(pre_samples);
                  post_m = (int'(post_samples) > 1024 - pre_m) ? 1024 - pre_m : int'(post_samples);
                  if (post_m < 1) post_m = 1;
                  hist.delete();
                  fill_m = 0;
                  ts_m   = 0;
                  ph     = 1;
               end
               1: begin
                  if (fill_m >= pre_m) ph = 2;
                  if (in_data_valid) begin
                     hist.push_back(in_data);
                     fill_m++;
                  end
               end
               2: begin
                  if (edge_m) begin
                     trig_idx = hist.size();
                     ts_m = 1;
                     ph   = 3;
                  end
                  if (in_data_valid) hist.push_back(in_data);
                  if (ph == 3) finish_post();
               end
               3: begin
                  if (in_data_valid) hist.push_back(in_data);
                  finish_post();
               end
               4: if (hs) begin
                  rx.push_back(m_axis_tdata);
                  beat++;
                  if (beat == exp_q.size()) begin
                     done_m = 1;
                     ph = 0;
                  end
               end
               default: ph = 0;
            endcase
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         chk("busy", busy, ph != 0);
         chk("trig_seen", trig_seen, ts_m);
         chk("capture_done", capture_done, done_m);
         if (ph == 4 && beat == 0) chk("first_valid_latency", m_axis_tvalid, rk >= 2);
         else if (ph != 4) chk("tvalid_outside_readout", m_axis_tvalid, 0);
         if (ph == 4 && stalled) chk("stall_hold_valid", m_axis_tvalid, 1);
         if (ph == 4 && m_axis_tvalid) begin
            if (beat < exp_q.size()) begin
               chk("tdata", m_axis_tdata, exp_q[beat]);
               chk("tlast", m_axis_tlast, beat == exp_q.size() - 1);
            end else begin
               chk("beat_overrun", beat, exp_q.size() - 1);
            end
         end
      end
   end

   int ramp;
   bit rdy_rand;

   task automatic cyc();
      @(posedge clk);
      #1;
      m_axis_tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
   endtask

   task automatic do_arm(input int p, input int q);
      in_data_valid = 0; trigger = 0;
      pre_samples = 16'(p); post_samples = 16'(q);
      arm = 1;
      cyc();
      arm = 0;
      ramp = 0;
      rx.delete();
   endtask

   // Ramp samples every `gap` cycles (0xDEAD on idle cycles), trigger on trig_val / early_val.
   task automatic run_capture(input int trig_val, input int early_val, input int gap,
                              input int abort_after);
      int  n = 0;
      bit  fired = 0;
      bit  done = 0;
      while (n < 5000 && !done) begin
         if (n % gap == 0) begin
            in_data_valid = 1;
            in_data = 16'(ramp);
            trigger = (ramp == trig_val) || (ramp == early_val);
            ramp++;
         end else begin
            in_data_valid = 0;
            in_data = 16'hDEAD;
            trigger = 0;
         end
         if (abort_after > 0 && rx.size() >= abort_after && !fired) begin
            abort = 1;
            fired = 1;
         end
         cyc();
         abort = 0;
         n++;
         if (!busy && ramp > trig_val) done = 1;
      end
      chk("capture_timeout", done, 1);
      in_data_valid = 0; trigger = 0;
   endtask

   task automatic idle(input int n);
      in_data_valid = 0; trigger = 0;
      repeat (n) cyc();
   endtask

   initial begin
      rst_n = 0; in_data_valid = 0; in_data = 0; trigger = 0; arm = 0; abort = 0;
      pre_samples = 0; post_samples = 0; m_axis_tready = 1; rdy_rand = 0; ramp = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_busy", busy, 0);
      chk("reset_tvalid", m_axis_tvalid, 0);
      chk("reset_tdata", m_axis_tdata, 0);
      chk("reset_trig_seen", trig_seen, 0);
      chk("reset_capture_done", capture_done, 0);
      rst_n = 1;
      idle(2);

      // 1: basic window
      do_arm(4, 4);
      run_capture(100, -1, 1, 0);
      chk("s1_len", rx.size(), 8);
      if (rx.size() == 8) begin
         chk("s1_first", rx[0], 96);
         chk("s1_last", rx[7], 103);
      end
      chk("s1_trig_seen", trig_seen, 1);
      idle(3);

      // 2: wrap across ring end from a clean write pointer
      rst_n = 0; #1; rst_n = 1;
      idle(2);
      do_arm(16, 32);
      run_capture(1000, -1, 1, 0);
      chk("s2_len", rx.size(), 48);
      if (rx.size() == 48) begin
         chk("s2_first", rx[0], 984);
         chk("s2_last", rx[47], 1031);
      end
      idle(3);

      // 3: random backpressure
      rdy_rand = 1;
      do_arm(4, 4);
      run_capture(100, -1, 1, 0);
      rdy_rand = 0;
      chk("s3_len", rx.size(), 8);
      if (rx.size() == 8) for (int i = 0; i < 8; i++) chk("s3_beat", rx[i], 96 + i);
      idle(3);

      // 4a: edge during fill ignored; 4b: clamping
      do_arm(8, 4);
      run_capture(50, 3, 1, 0);
      chk("s4a_len", rx.size(), 12);
      if (rx.size() == 12) chk("s4a_first", rx[0], 42);
      idle(3);
      do_arm(2000, 0);
      run_capture(1100, -1, 1, 0);
      chk("s4b_len", rx.size(), 1024);
      if (rx.size() == 1024) begin
         chk("s4b_first", rx[0], 77);
         chk("s4b_last", rx[1023], 1100);
      end
      idle(3);

      // 5a: abort mid readout
      do_arm(4, 4);
      run_capture(100, -1, 1, 3);
      chk("s5_abort_tvalid", m_axis_tvalid, 0);
      chk("s5_abort_busy", busy, 0);
      chk("s5_abort_trig_seen", trig_seen, 1);
      idle(5);

      // 5b: async reset mid-post, then re-arm
      do_arm(4, 40);
      for (int i = 0; i < 112; i++) begin
         in_data_valid = 1; in_data = 16'(ramp); trigger = (ramp == 100); ramp++;
         cyc();
      end
      chk("s5_busy_before_reset", busy, 1);
      rst_n = 0;
      #1;
      chk("s5_rst_busy", busy, 0);
      chk("s5_rst_tvalid", m_axis_tvalid, 0);
      chk("s5_rst_tlast", m_axis_tlast, 0);
      chk("s5_rst_tdata", m_axis_tdata, 0);
      chk("s5_rst_trig_seen", trig_seen, 0);
      chk("s5_rst_capture_done", capture_done, 0);
      in_data_valid = 0; trigger = 0;
      @(posedge clk); #3;
      rst_n = 1;
      idle(2);
      do_arm(4, 4);
      run_capture(200, -1, 1, 0);
      chk("s5_rearm_len", rx.size(), 8);
      if (rx.size() == 8) chk("s5_rearm_first", rx[0], 196);
      idle(3);

      // 6: gapped input
      do_arm(5, 5);
      run_capture(60, -1, 3, 0);
      chk("s6_len", rx.size(), 10);
      if (rx.size() == 10) for (int i = 0; i < 10; i++) chk("s6_beat", rx[i], 55 + i);
      idle(3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
